// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: tracks a frame's running remainder modulo DIVISOR,
// one bit per cycle, MSB-first or LSB-first, and registers a result at frame end.
module serial_mod_checker #(
  parameter  int DIVISOR  = 5,
  parameter  int MAX_BITS = 32,
  localparam int RW       = $clog2(DIVISOR),
  localparam int CW       = $clog2(MAX_BITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          in_last,
  input  logic          msb_first,
  output logic [RW-1:0] rem,
  output logic          z,
  output logic          done,
  output logic [RW-1:0] result_rem,
  output logic          result_z,
  output logic [CW-1:0] bit_cnt,
  output logic          ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

  localparam logic [RW:0]   DIV_W   = (RW + 1)'(DIVISOR);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BITS);

  state_t        state_q, state_d;
  logic [RW-1:0] acc_q, acc_d;
  logic [RW-1:0] wgt_q, wgt_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;
  logic [RW-1:0] result_rem_q, result_rem_d;
  logic          result_z_q, result_z_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          ovf_q, ovf_d;
  logic          use_msb;
  logic [RW-1:0] acc_new;

  // Inputs are always below 2*DIVISOR, so one subtract brings them back into range.
  function automatic logic [RW-1:0] cond_sub(input logic [RW:0] t);
    if (t >= DIV_W) begin
      return RW'(t - DIV_W);
    end else begin
      return RW'(t);
    end
  endfunction

  // Next-state and next-remainder computation.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    wgt_d        = wgt_q;
    mode_d       = mode_q;
    done_d       = 1'b0;
    result_rem_d = result_rem_q;
    result_z_d   = result_z_q;
    bit_cnt_d    = bit_cnt_q;
    ovf_d        = ovf_q;

    // The first bit of a frame uses the live msb_first; later bits use the latched mode.
    case (state_q)
      IDLE:    use_msb = msb_first;
      ACC:     use_msb = mode_q;
      default: use_msb = mode_q;
    endcase

    if (use_msb) begin
      acc_new = cond_sub({acc_q, in_bit});
    end else begin
      acc_new = cond_sub({1'b0, acc_q} + (in_bit ? {1'b0, wgt_q} : {(RW + 1){1'b0}}));
    end

    if (in_valid) begin
      if (state_q == IDLE) begin
        mode_d = msb_first;
      end else begin
        mode_d = mode_q;
      end
      if (in_last) begin
        result_rem_d = acc_new;
        result_z_d   = (acc_new == {RW{1'b0}});
        done_d       = 1'b1;
        acc_d        = {RW{1'b0}};
        wgt_d        = RW'(1'b1);
        bit_cnt_d    = {CW{1'b0}};
        ovf_d        = 1'b0;
        state_d      = IDLE;
      end else begin
        acc_d   = acc_new;
        wgt_d   = cond_sub({wgt_q, 1'b0});
        state_d = ACC;
        if (bit_cnt_q == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1'b1);
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= {RW{1'b0}};
      wgt_q        <= RW'(1'b1);
      mode_q       <= 1'b1;
      done_q       <= 1'b0;
      result_rem_q <= {RW{1'b0}};
      result_z_q   <= 1'b0;
      bit_cnt_q    <= {CW{1'b0}};
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      wgt_q        <= wgt_d;
      mode_q       <= mode_d;
      done_q       <= done_d;
      result_rem_q <= result_rem_d;
      result_z_q   <= result_z_d;
      bit_cnt_q    <= bit_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rem        = acc_q;
  assign z          = (acc_q == {RW{1'b0}});
  assign done       = done_q;
  assign result_rem = result_rem_q;
  assign result_z   = result_z_q;
  assign bit_cnt    = bit_cnt_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: a DIVISOR=5 instance driven from a vector table and
// hand sequences, and a DIVISOR=3/MAX_BITS=8 instance for saturation and a full sweep.
module tb_serial_mod_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst5, v5, b5, l5, m5;
  logic [2:0] rem5, rrem5;
  logic       z5, done5, rz5, ovf5;
  logic [5:0] cnt5;

  logic       rst3, v3, b3, l3, m3;
  logic [1:0] rem3, rrem3;
  logic       z3, done3, rz3, ovf3;
  logic [3:0] cnt3;

  serial_mod_checker #(.DIVISOR(5), .MAX_BITS(32)) u5 (
    .clk(clk), .rst(rst5), .in_valid(v5), .in_bit(b5), .in_last(l5), .msb_first(m5),
    .rem(rem5), .z(z5), .done(done5), .result_rem(rrem5), .result_z(rz5),
    .bit_cnt(cnt5), .ovf(ovf5));

  serial_mod_checker #(.DIVISOR(3), .MAX_BITS(8)) u3 (
    .clk(clk), .rst(rst3), .in_valid(v3), .in_bit(b3), .in_last(l3), .msb_first(m3),
    .rem(rem3), .z(z3), .done(done3), .result_rem(rrem3), .result_z(rz3),
    .bit_cnt(cnt3), .ovf(ovf3));

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int r; int z; } res_t;
  res_t q5[$];
  res_t q3[$];
  res_t e5, e3;

  typedef struct {
    logic v, b, l, m;
    int   rem, z, done, rr, rz;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive5(input logic v, input logic b, input logic l, input logic m);
    v5 = v; b5 = b; l5 = l; m5 = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive3(input logic v, input logic b, input logic l, input logic m);
    v3 = v; b3 = b; l3 = l; m3 = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every done pulse must match the oldest pending frame result.
  always @(negedge clk) begin
    if (done5 === 1'b1) begin
      if (q5.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done5_spurious: got done=1, expected no pending result");
      end else begin
        e5 = q5.pop_front();
        chk("res5_rem", int'(rrem5), e5.r);
        chk("res5_z", int'(rz5), e5.z);
      end
    end
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL done3_spurious: got done=1, expected no pending result");
      end else begin
        e3 = q3.pop_front();
        chk("res3_rem", int'(rrem3), e3.r);
        chk("res3_z", int'(rz3), e3.z);
      end
    end
  end

  initial begin
    logic       gbits[4];
    int         grem[4];
    logic       obits[10];
    int         pv;
    logic [7:0] vb;
    logic       bb;

    //               v     b     l     m    rem z done rr rz
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1, 0, 1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 2, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 0, 1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 1, 1, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1, 0, 1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0, 0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 1, 0};

    rst5 = 1'b1; v5 = 1'b0; b5 = 1'b0; l5 = 1'b0; m5 = 1'b0;
    rst3 = 1'b1; v3 = 1'b0; b3 = 1'b0; l3 = 1'b0; m3 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    chk("rst5_rem", int'(rem5), 0);
    chk("rst5_z", int'(z5), 1);
    chk("rst5_done", int'(done5), 0);
    chk("rst5_rrem", int'(rrem5), 0);
    chk("rst5_rz", int'(rz5), 0);
    chk("rst5_cnt", int'(cnt5), 0);
    chk("rst5_ovf", int'(ovf5), 0);
    chk("rst3_rem", int'(rem3), 0);
    chk("rst3_z", int'(z3), 1);
    chk("rst3_cnt", int'(cnt3), 0);
    rst5 = 1'b0;
    rst3 = 1'b0;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].v && tbl[i].l) q5.push_back('{tbl[i].rr, tbl[i].rz});
      drive5(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].m);
      chk($sformatf("vec%0d_rem", i), int'(rem5), tbl[i].rem);
      chk($sformatf("vec%0d_z", i), int'(z5), tbl[i].z);
      chk($sformatf("vec%0d_done", i), int'(done5), tbl[i].done);
    end

    // 13 MSB-first with three-cycle gaps of junk; previous result (1) must hold.
    gbits = '{1'b1, 1'b1, 1'b0, 1'b1};
    grem  = '{1, 3, 1, 0};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q5.push_back('{3, 0});
      drive5(1'b1, gbits[i], (i == 3), 1'b1);
      chk($sformatf("gap_bit%0d_rem", i), int'(rem5), grem[i]);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          drive5(1'b0, 1'b1, 1'b1, 1'b0);
          chk($sformatf("gap%0d_%0d_rem", i, g), int'(rem5), grem[i]);
          chk($sformatf("gap%0d_%0d_hold", i, g), int'(rrem5), 1);
          chk($sformatf("gap%0d_%0d_done", i, g), int'(done5), 0);
        end
      end
    end

    // Reset mid-frame, overlapping an accepted last bit: frame dropped, no done.
    drive5(1'b1, 1'b1, 1'b0, 1'b1);
    drive5(1'b1, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_rem", int'(rem5), 3);
    rst5 = 1'b1;
    drive5(1'b1, 1'b1, 1'b1, 1'b1);
    rst5 = 1'b0;
    chk("mid_rst_rem", int'(rem5), 0);
    chk("mid_rst_z", int'(z5), 1);
    chk("mid_rst_done", int'(done5), 0);
    chk("mid_rst_rrem", int'(rrem5), 0);
    chk("mid_rst_rz", int'(rz5), 0);
    q5.push_back('{0, 1});
    drive5(1'b1, 1'b0, 1'b1, 1'b1);
    chk("post_rst_done", int'(done5), 1);
    drive5(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_done_clr", int'(done5), 0);
    chk("post_rst_rz_hold", int'(rz5), 1);

    // 876 MSB-first over a MAX_BITS=8 counter: saturation and sticky overflow.
    obits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pv = 0;
    for (int i = 0; i < 10; i++) begin
      pv = (pv * 2 + int'(obits[i])) % 3;
      if (i == 9) q3.push_back('{0, 1});
      drive3(1'b1, obits[i], (i == 9), 1'b1);
      chk($sformatf("sat%0d_cnt", i), int'(cnt3), (i == 9) ? 0 : ((i + 1 > 8) ? 8 : i + 1));
      chk($sformatf("sat%0d_ovf", i), int'(ovf3), (i == 8) ? 1 : 0);
      chk($sformatf("sat%0d_rem", i), int'(rem3), (i == 9) ? 0 : pv);
    end

    // Every 8-bit value, both bit orders, frames back to back.
    for (int mode = 0; mode < 2; mode++) begin
      for (int val = 0; val < 256; val++) begin
        vb = val[7:0];
        pv = 0;
        for (int k = 0; k < 8; k++) begin
          bb = (mode == 1) ? vb[7 - k] : vb[k];
          if (mode == 1) pv = pv * 2 + int'(bb);
          else           pv = pv + (int'(bb) << k);
          if (k == 7) q3.push_back('{val % 3, (val % 3 == 0) ? 1 : 0});
          drive3(1'b1, bb, (k == 7), (mode == 1));
          if (k == 7 || k == 3)
            chk($sformatf("sw_m%0d_v%0d_k%0d_rem", mode, val, k), int'(rem3), (k == 7) ? 0 : pv % 3);
        end
      end
    end

    drive3(1'b0, 1'b0, 1'b0, 1'b0);
    drive3(1'b0, 1'b0, 1'b0, 1'b0);
    chk("q5_drained", q5.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
